// File: rtl/div_arbiter.sv
// Two-requester front end for a shared iterative divider, with a one-entry
// result cache that lets an exact repeat of the last good operation skip the divider.
module div_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_dividend,
  input  logic [31:0] req0_divisor,
  input  logic [1:0]  req0_type,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_dividend,
  input  logic [31:0] req1_divisor,
  input  logic [1:0]  req1_type,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_exc,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_exc,

  output logic        div_in_valid,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic [1:0]  div_type,
  output logic        div_cpu_busy,
  input  logic [31:0] div_out,
  input  logic        div_out_valid,
  input  logic        div_busy,
  input  logic        div_exception,

  input  logic        cache_flush
);

  // state | meaning
  // IDLE  | waiting for a request; accepts only while the divider is idle
  // ISSUE | one-cycle start pulse to the divider
  // WAIT  | operands held until the divider returns a result
  // RESP  | result presented to the granted requester until consumed
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        ptr, gid, grant;
  logic [31:0] op_a, op_b, rsp_data_q;
  logic [1:0]  op_t;
  logic        rsp_exc_q;
  logic        c_vld;
  logic [31:0] c_a, c_b, c_d;
  logic [1:0]  c_t;
  logic        can_accept, accept, hit, rsp_hs;
  logic [31:0] sel_a, sel_b;
  logic [1:0]  sel_t;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ptr;
    else if (req1_valid)          grant = 1'b1;
  end

  // Gating ready with rst keeps every output low while reset is held.
  assign can_accept = (state == IDLE) && !div_busy && !rst;
  assign req0_ready = can_accept && req0_valid && !grant;
  assign req1_ready = can_accept && req1_valid && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_a = grant ? req1_dividend : req0_dividend;
  assign sel_b = grant ? req1_divisor  : req0_divisor;
  assign sel_t = grant ? req1_type     : req0_type;

  assign hit = c_vld && !cache_flush && (c_a == sel_a) && (c_b == sel_b) && (c_t == sel_t);

  assign rsp_hs = (state == RESP) && (gid ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = hit ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (div_out_valid) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= 1'b0;
      gid        <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_t       <= '0;
      rsp_data_q <= '0;
      rsp_exc_q  <= 1'b0;
      c_vld      <= 1'b0;
      c_a        <= '0;
      c_b        <= '0;
      c_t        <= '0;
      c_d        <= '0;
    end else begin
      if (cache_flush) c_vld <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_a <= sel_a;
          op_b <= sel_b;
          op_t <= sel_t;
          gid  <= grant;
          if (hit) begin
            rsp_data_q <= c_d;
            rsp_exc_q  <= 1'b0;
          end
        end
        WAIT: if (div_out_valid) begin
          rsp_data_q <= div_out;
          rsp_exc_q  <= div_exception;
          // Faulting results are never cached; a flush overrides the fill.
          if (!div_exception && !cache_flush) begin
            c_vld <= 1'b1;
            c_a   <= op_a;
            c_b   <= op_b;
            c_t   <= op_t;
            c_d   <= div_out;
          end
        end
        RESP: if (rsp_hs) ptr <= ~gid;
        default: ;
      endcase
    end
  end

  assign div_in_valid = (state == ISSUE);
  assign div_dividend = op_a;
  assign div_divisor  = op_b;
  assign div_type     = op_t;
  assign div_cpu_busy = 1'b0;

  assign rsp0_valid = (state == RESP) && !gid;
  assign rsp1_valid = (state == RESP) && gid;
  assign rsp0_data  = rsp_data_q;
  assign rsp1_data  = rsp_data_q;
  assign rsp0_exc   = rsp_exc_q;
  assign rsp1_exc   = rsp_exc_q;

endmodule
